// File: rtl/bus_pkg.sv
// Shared bus types for the two-master arbiter, the CPU and the loader.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data_w;
        logic [3:0]  mask_w;
    } bus_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner selection: round-robin on ties, or fixed priority to master 0.
module rr_pick2 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = (ROUND_ROBIN != 0) ? ~last : 1'b0;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates two masters onto one registered memory bus: IDLE -> ACCESS -> RESP.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_data_w,
    input  logic [3:0]  m0_mask_w,
    output logic        m0_ack,
    output logic [31:0] m0_data_r,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_data_w,
    input  logic [3:0]  m1_mask_w,
    output logic        m1_ack,
    output logic [31:0] m1_data_r,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data_w,
    output logic [3:0]  bus_mask_w,
    input  logic [31:0] bus_data_r
);

    arb_state_t state;
    logic       gnt;
    logic       last;
    bus_req_t   bus_q;
    bus_req_t   m0_fields;
    bus_req_t   m1_fields;
    logic       pick_winner;
    logic       pick_valid;
    logic       other_req;

    assign m0_fields = {m0_addr, m0_data_w, m0_mask_w};
    assign m1_fields = {m1_addr, m1_data_w, m1_mask_w};

    // The master just served is ignored in RESP; only the other one may chain in.
    assign other_req = gnt ? m0_req : m1_req;

    rr_pick2 #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_pick (
        .req0  (m0_req),
        .req1  (m1_req),
        .last  (last),
        .winner(pick_winner),
        .valid (pick_valid)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            bus_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        bus_q <= pick_winner ? m1_fields : m0_fields;
                        gnt   <= pick_winner;
                        last  <= pick_winner;
                        state <= ACCESS;
                    end else begin
                        bus_q.mask_w <= '0;
                    end
                end
                ACCESS: begin
                    bus_q.mask_w <= '0;
                    state        <= RESP;
                end
                RESP: begin
                    if (other_req) begin
                        bus_q <= gnt ? m0_fields : m1_fields;
                        gnt   <= ~gnt;
                        last  <= ~gnt;
                        state <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_addr   = bus_q.addr;
    assign bus_data_w = bus_q.data_w;
    assign bus_mask_w = bus_q.mask_w;

    assign m0_ack    = (state == RESP) && !gnt;
    assign m1_ack    = (state == RESP) && gnt;
    assign m0_data_r = m0_ack ? bus_data_r : '0;
    assign m1_data_r = m1_ack ? bus_data_r : '0;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1, meaning: 1 = alternate priority between masters; 0 = master 0 always wins.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0_req  input  1  master 0 (CPU) access request; held high until m0_ack.
REQ-005 m0_addr  input  32  master 0 word address.
REQ-006 m0_data_w  input  32  master 0 write data.
REQ-007 m0_mask_w  input  4  master 0 byte write enables; 0 = read.
REQ-008 m0_ack  output  1  one-cycle completion pulse to master 0.
REQ-009 m0_data_r  output  32  master 0 read data, valid only while m0_ack=1.
REQ-010 m1_req, m1_addr, m1_data_w, m1_mask_w, m1_ack, m1_data_r  same directions, widths and meanings for master 1 (loader/DMA).
REQ-011 bus_addr  output  32  registered address to memory.
REQ-012 bus_data_w  output  32  registered write data to memory.
REQ-013 bus_mask_w  output  4  registered byte write enables to memory.
REQ-014 bus_data_r  input  32  memory read data, valid one clock after bus_addr is presented.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP, plus a 1-bit register gnt identifying the master being served.
REQ-016 In IDLE with at least one request pending, the block SHALL select a winner, latch that master's addr/data_w/mask_w into the bus registers, set gnt, and go to ACCESS.
REQ-017 In IDLE with no request pending, the block SHALL stay in IDLE and hold bus_mask_w=0.
REQ-018 ACCESS SHALL last exactly one cycle, driving the latched values on the bus, then go to RESP.
REQ-019 On the ACCESS->RESP edge, bus_mask_w SHALL be cleared to 0; bus_addr SHALL be held.
REQ-020 In RESP, the block SHALL assert the gnt master's ack for exactly one cycle, with its data_r equal to bus_data_r (writes also return bus_data_r).
REQ-021 The non-granted master's ack SHALL be 0 at all times.
REQ-022 In RESP, the served master's req SHALL be ignored.
REQ-023 In RESP, if the other master requests, the block SHALL grant it and go directly to ACCESS; otherwise it SHALL go to IDLE.
REQ-024 Latency from req sampled in IDLE to ack SHALL be 2 cycles.
REQ-025 Sustained throughput SHALL be one access per 2 cycles when masters alternate, and one per 3 cycles for a single master.
REQ-026 With ROUND_ROBIN=1 and simultaneous requests in IDLE, the master not served most recently SHALL win; the last-served pointer resets to master 1, so master 0 wins first.
REQ-027 With ROUND_ROBIN=0, master 0 SHALL win every IDLE tie.
REQ-028 Request fields SHALL be sampled only at grant; later changes SHALL not affect the access in flight.
REQ-029 Write enables SHALL be nonzero on the bus only in ACCESS, so at most one write per grant.

Reset
REQ-030 Asserting reset SHALL immediately force the state to IDLE, gnt=0, last-served=master 1, and all of bus_addr, bus_data_w, bus_mask_w, m0_ack, m1_ack, m0_data_r and m1_data_r to 0.
REQ-031 Reset during ACCESS or RESP SHALL abort the access with no ack; a write already sampled by memory is not undone.
REQ-032 After reset deasserts, the first grant SHALL occur on the first rising edge at which a request is seen.

Structure
REQ-033 Enum arb_state_t {IDLE, ACCESS, RESP} and a struct bus_req_t {addr, data_w, mask_w} SHALL live in shared package bus_pkg for reuse by the CPU and loader.
REQ-034 Winner selection SHALL be a sub-module rr_pick2 (inputs: two reqs, last-served, ROUND_ROBIN; output: winner index and valid).

Verification
REQ-035 Lone m0 read, addr=0x10, memory word 0xDEADBEEF -> bus_addr=0x10 in cycle T+1, m0_ack=1 with m0_data_r=0xDEADBEEF in T+2, m1_ack=0 throughout.
REQ-036 m1 write, addr=0x20, data=0x12345678, mask=0x3 -> bus_mask_w=0x3 for exactly one cycle; a subsequent m0 read of 0x20 returns the low half 0x5678 merged with the old upper half.
REQ-037 m0 and m1 both held high for 8 accesses, ROUND_ROBIN=1 -> acks alternate m0,m1,m0,... one ack every 2 cycles; with ROUND_ROBIN=0 m0 gets every IDLE tie.
REQ-038 m0 holds req through its ack cycle (RESP) -> no back-to-back regrant; the next m0 ack arrives 3 cycles after the previous one.
REQ-039 Reset asserted mid-cycle during ACCESS of an m1 write -> bus_mask_w=0 and state IDLE immediately; no m1_ack occurs; next m0 request completes normally.
REQ-040 m1 changes addr from 0x30 to 0x40 during ACCESS -> bus_addr stays 0x30 and the acked data comes from 0x30.
